// File: rtl/pe_result_drain.sv
// pe_result_drain: per-lane result FIFOs between the PE array and the AXI
// read-back path. While idle it captures one result word per lane per cycle.
// A save_sop pulse drains the lanes in ascending order over a valid/ready
// stream and returns one rd_eop pulse per lane, empty lanes included.

module pe_result_drain #(
  parameter int LANES = 8,
  parameter int DEPTH = 8,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LANES-1:0]         wr_en,
  input  logic [LANES*DW-1:0]      wr_data,
  input  logic                     save_sop,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DW-1:0]            m_data,
  output logic [$clog2(LANES)-1:0] m_lane,
  output logic                     m_last,
  output logic [LANES-1:0]         rd_eop,
  output logic                     busy,
  output logic                     drain_done,
  output logic                     ovf
);

  localparam int LW = $clog2(LANES);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0]    CNT_ZERO  = CW'(1'b0);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1'b1);
  localparam logic [CW-1:0]    CNT_FULL  = CW'(DEPTH);
  localparam logic [LW-1:0]    LANE_ZERO = LW'(1'b0);
  localparam logic [LW-1:0]    LANE_ONE  = LW'(1'b1);
  localparam logic [LW-1:0]    LANE_LAST = LW'(LANES - 1);
  localparam logic [PW-1:0]    PTR_ONE   = PW'(1'b1);
  localparam logic [LANES-1:0] EOP_LANE0 = LANES'(1'b1);
  localparam logic [LANES-1:0] EOP_NONE  = LANES'(1'b0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state_r;
  state_t state_next_s;

  // Per-lane storage and bookkeeping
  logic [DW-1:0]    mem_r    [LANES][DEPTH];
  logic [PW-1:0]    wr_ptr_r [LANES];
  logic [PW-1:0]    rd_ptr_r [LANES];
  logic [CW-1:0]    count_r  [LANES];

  logic [LW-1:0]    lane_idx_r;
  logic [LW-1:0]    lane_idx_next_s;
  logic [LANES-1:0] rd_eop_r;
  logic             drain_done_r;
  logic             ovf_r;

  logic [LANES-1:0] push_s;
  logic [LANES-1:0] pop_s;
  logic             drop_s;
  logic [CW-1:0]    cur_count_s;
  logic             valid_s;
  logic             beat_s;
  logic             lane_done_s;
  logic             last_lane_s;

  // Current-lane view: occupancy, stream handshake and lane completion
  always_comb begin
    cur_count_s = count_r[lane_idx_r];
    valid_s     = (state_r == ST_DRAIN) && (cur_count_s != CNT_ZERO);
    beat_s      = valid_s && m_ready;
    last_lane_s = (lane_idx_r == LANE_LAST);
    // An empty lane finishes immediately; a busy lane finishes on its last pop.
    lane_done_s = (state_r == ST_DRAIN) &&
                  ((cur_count_s == CNT_ZERO) || (beat_s && (cur_count_s == CNT_ONE)));
  end

  // Write acceptance: push only in IDLE with room, anything else is dropped
  always_comb begin
    push_s = LANES'(1'b0);
    drop_s = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (wr_en[i]) begin
        if ((state_r == ST_IDLE) && (count_r[i] != CNT_FULL)) begin
          push_s[i] = 1'b1;
        end else begin
          drop_s = 1'b1;
        end
      end else begin
        push_s[i] = 1'b0;
      end
    end
  end

  // Pop decode: the stream beat retires the head of the lane being drained
  always_comb begin
    pop_s = LANES'(1'b0);
    for (int i = 0; i < LANES; i++) begin
      pop_s[i] = beat_s && (lane_idx_r == LW'(i));
    end
  end

  // Next-state and lane-index sequencing
  always_comb begin
    state_next_s    = state_r;
    lane_idx_next_s = lane_idx_r;
    case (state_r)
      ST_IDLE: begin
        if (save_sop) begin
          state_next_s    = ST_DRAIN;
          lane_idx_next_s = LANE_ZERO;
        end else begin
          state_next_s    = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (lane_done_s) begin
          if (last_lane_s) begin
            state_next_s    = ST_DONE;
          end else begin
            lane_idx_next_s = lane_idx_r + LANE_ONE;
          end
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_next_s    = ST_IDLE;
        lane_idx_next_s = LANE_ZERO;
      end
      default: begin
        state_next_s    = ST_IDLE;
        lane_idx_next_s = LANE_ZERO;
      end
    endcase
  end

  // Control registers: state, lane index, completion pulses, sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      lane_idx_r   <= LANE_ZERO;
      rd_eop_r     <= EOP_NONE;
      drain_done_r <= 1'b0;
      ovf_r        <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      lane_idx_r   <= lane_idx_next_s;
      rd_eop_r     <= lane_done_s ? (EOP_LANE0 << lane_idx_r) : EOP_NONE;
      drain_done_r <= lane_done_s && last_lane_s;
      ovf_r        <= ovf_r | drop_s;
    end
  end

  // FIFO pointers and counts; push (IDLE only) and pop (DRAIN only) never coincide
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) begin
        wr_ptr_r[i] <= PW'(1'b0);
        rd_ptr_r[i] <= PW'(1'b0);
        count_r[i]  <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (push_s[i]) begin
          wr_ptr_r[i] <= wr_ptr_r[i] + PTR_ONE;
          count_r[i]  <= count_r[i] + CNT_ONE;
        end else if (pop_s[i]) begin
          rd_ptr_r[i] <= rd_ptr_r[i] + PTR_ONE;
          count_r[i]  <= count_r[i] - CNT_ONE;
        end
      end
    end
  end

  // FIFO storage; contents need no reset since counts gate visibility
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (push_s[i]) begin
        mem_r[i][wr_ptr_r[i]] <= wr_data[i*DW +: DW];
      end
    end
  end

  assign m_valid    = valid_s;
  assign m_data     = mem_r[lane_idx_r][rd_ptr_r[lane_idx_r]];
  assign m_lane     = lane_idx_r;
  assign m_last     = valid_s && (cur_count_s == CNT_ONE);
  assign rd_eop     = rd_eop_r;
  assign busy       = (state_r != ST_IDLE);
  assign drain_done = drain_done_r;
  assign ovf        = ovf_r;

endmodule

// File: tb/tb_pe_result_drain.sv
// Directed bench for pe_result_drain: a per-lane reference queue supplies the
// expected stream; every comparison is an immediate assertion.
`timescale 1ns/1ps

module tb_pe_result_drain;

  localparam int LANES = 8;
  localparam int DEPTH = 8;
  localparam int DW    = 32;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [LANES-1:0]    wr_en = '0;
  logic [LANES*DW-1:0] wr_data = '0;
  logic                save_sop = 1'b0;
  logic                m_valid;
  logic                m_ready = 1'b0;
  logic [DW-1:0]       m_data;
  logic [2:0]          m_lane;
  logic                m_last;
  logic [LANES-1:0]    rd_eop;
  logic                busy;
  logic                drain_done;
  logic                ovf;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: expected words per lane
  logic [DW-1:0] mdl_data [LANES][16];
  int            mdl_wr   [LANES];
  int            mdl_rd   [LANES];

  pe_result_drain #(.LANES(LANES), .DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .save_sop(save_sop),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_lane(m_lane),
    .m_last(m_last), .rd_eop(rd_eop), .busy(busy), .drain_done(drain_done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < LANES; i++) begin
      mdl_wr[i] = 0;
      mdl_rd[i] = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    mdl_clear();
  endtask

  // One write cycle in IDLE; the model keeps only what fits
  task automatic write_cycle(input logic [LANES-1:0] mask, input logic [LANES*DW-1:0] data,
                             input logic with_sop);
    wr_en    = mask;
    wr_data  = data;
    save_sop = with_sop;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i] && (mdl_wr[i] - mdl_rd[i]) < DEPTH) begin
        mdl_data[i][mdl_wr[i] % 16] = data[i*DW +: DW];
        mdl_wr[i]++;
      end
    end
    tick();
    wr_en    = '0;
    save_sop = 1'b0;
  endtask

  task automatic start_drain();
    save_sop = 1'b1;
    tick();
    save_sop = 1'b0;
  endtask

  // Drive m_ready and watch the stream until the block returns to IDLE
  task automatic run_drain(input int ready_mode, input int sop_at, input int wr_at,
                           input int exp_beats, input int exp_busy);
    int            beats     = 0;
    int            busy_cyc  = 0;
    int            eops      = 0;
    int            lane;
    int            left;
    logic          stalled   = 1'b0;
    logic [DW-1:0] hold_data = '0;
    logic [2:0]    hold_lane = '0;
    logic          hold_last = 1'b0;
    logic [7:0]    eop_due   = '0;
    logic          done_seen = 1'b0;
    logic          finished  = 1'b0;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      m_ready  = (ready_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      save_sop = (cyc == sop_at);
      if (cyc == wr_at) begin
        wr_en   = 8'hFF;
        wr_data = {8{32'hDEAD_0000}};
      end else begin
        wr_en   = 8'h00;
      end
      if (done_seen) begin
        chk("busy_after_done", busy, 1'b0);
        chk("eop_after_done", rd_eop, 8'h00);
        finished = 1'b1;
      end else begin
        if (busy) busy_cyc++;
        if (eop_due != 8'h00) begin
          chk("eop_after_last", rd_eop, eop_due);
          eop_due = 8'h00;
        end
        if (rd_eop != 8'h00) begin
          chk("eop_order", rd_eop, 8'h01 << eops);
          eops++;
        end
        chk("done_vs_eop7", drain_done, rd_eop[7]);
        if (drain_done) done_seen = 1'b1;
        if (stalled) begin
          chk("stall_valid", m_valid, 1'b1);
          chk("stall_data", m_data, hold_data);
          chk("stall_lane", m_lane, hold_lane);
          chk("stall_last", m_last, hold_last);
        end
        if (m_valid) begin
          lane = eops;
          left = (lane < LANES) ? (mdl_wr[lane] - mdl_rd[lane]) : 0;
          if (left > 0) begin
            chk("beat_lane", m_lane, lane);
            chk("beat_last", m_last, (left == 1));
            if (m_ready) begin
              chk("beat_data", m_data, mdl_data[lane][mdl_rd[lane] % 16]);
              mdl_rd[lane]++;
              beats++;
              if (left == 1) eop_due = 8'h01 << lane;
            end
          end else begin
            chk("unexpected_beat", m_valid, 1'b0);
          end
        end
        stalled   = m_valid && !m_ready;
        hold_data = m_data;
        hold_lane = m_lane;
        hold_last = m_last;
        tick();
      end
    end
    m_ready  = 1'b0;
    save_sop = 1'b0;
    wr_en    = '0;
    chk("drain_finished", finished, 1'b1);
    chk("beat_count", beats, exp_beats);
    chk("eop_count", eops, LANES);
    if (exp_busy >= 0) chk("busy_cycles", busy_cyc, exp_busy);
  endtask

  logic [LANES*DW-1:0] vec;

  initial begin
    mdl_clear();

    // Reset state
    do_reset();
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd_eop", rd_eop, 8'h00);
    chk("rst_drain_done", drain_done, 1'b0);
    chk("rst_ovf", ovf, 1'b0);

    // Full drain: 3 words per lane, value 0x100+lane, m_ready held high
    for (int i = 0; i < LANES; i++) vec[i*DW +: DW] = 32'h100 + 32'(i);
    for (int k = 0; k < 3; k++) write_cycle(8'hFF, vec, 1'b0);
    start_drain();
    run_drain(0, -1, -1, 24, 25);

    // Only lanes 2 and 5 hold a word
    for (int i = 0; i < LANES; i++) vec[i*DW +: DW] = 32'h200 + 32'(i);
    write_cycle(8'h24, vec, 1'b0);
    start_drain();
    run_drain(0, -1, -1, 2, 9);

    // Backpressure with distinct words per write
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < LANES; i++) vec[i*DW +: DW] = 32'h300 + 32'(i * 16 + k);
      write_cycle(8'hFF, vec, 1'b0);
    end
    start_drain();
    run_drain(1, -1, -1, 24, -1);

    // Overflow on lane 3, then writes during drain
    for (int k = 0; k < 9; k++) begin
      vec = '0;
      vec[3*DW +: DW] = 32'h400 + 32'(k);
      write_cycle(8'h08, vec, 1'b0);
      if (k == 7) chk("ovf_after_8", ovf, 1'b0);
    end
    chk("ovf_after_9", ovf, 1'b1);
    start_drain();
    run_drain(0, -1, 3, 8, 16);
    chk("ovf_sticky", ovf, 1'b1);
    start_drain();
    run_drain(0, -1, -1, 0, 9);

    // save_sop together with a lane-0 write; second save_sop mid-drain ignored
    do_reset();
    chk("ovf_cleared", ovf, 1'b0);
    vec = '0;
    vec[0 +: DW] = 32'h0000_00AA;
    write_cycle(8'h01, vec, 1'b1);
    chk("sop_wr_busy", busy, 1'b1);
    run_drain(0, 2, -1, 1, 9);
    for (int k = 0; k < 3; k++) begin
      chk("no_restart_busy", busy, 1'b0);
      chk("no_extra_eop", rd_eop, 8'h00);
      tick();
    end

    // Reset after 5 beats of a 24-word drain
    for (int i = 0; i < LANES; i++) vec[i*DW +: DW] = 32'h500 + 32'(i);
    for (int k = 0; k < 3; k++) write_cycle(8'hFF, vec, 1'b0);
    start_drain();
    m_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("pre_rst_busy", busy, 1'b1);
    rst     = 1'b1;
    m_ready = 1'b0;
    tick();
    chk("midrst_m_valid", m_valid, 1'b0);
    chk("midrst_rd_eop", rd_eop, 8'h00);
    chk("midrst_busy", busy, 1'b0);
    rst = 1'b0;
    mdl_clear();
    start_drain();
    run_drain(0, -1, -1, 0, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
